mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sits directly downstream of the pipelined CPU core and merges its instruction-fetch port (read-only) and data port (read/write, byte-masked) onto a single physical-memory port with a request/response handshake. Both client requests are latched, granted one at a time with alternating priority under contention, and each client receives a one-cycle resp pulse with held read data. A watchdog counter flags a memory that never responds.

Parameters:
TIMEOUT_CYCLES, 255, BUSY cycles without mem_resp before err sets; 0 disables the watchdog.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
inst_read  in  1  instruction fetch request, held until inst_resp
inst_addr  in  32  fetch address
inst_rdata  out  32  fetched word, held until next inst response
inst_resp  out  1  one-cycle fetch completion pulse
data_read  in  1  data load request, held until data_resp
data_write  in  1  data store request, held until data_resp
data_mbe  in  4  store byte enables
data_addr  in  32  load/store address
data_wdata  in  32  store data
data_rdata  out  32  loaded word, held until next data response
data_resp  out  1  one-cycle load/store completion pulse
mem_read  out  1  memory read strobe, held until mem_resp
mem_write  out  1  memory write strobe, held until mem_resp
mem_mbe  out  4  memory byte enables
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid when mem_resp=1
mem_resp  in  1  memory completion, one cycle
err  out  1  sticky watchdog/protocol error flag

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs 0; last_grant=DATA (first contended grant goes to INST); watchdog count 0; err 0. Reset mid-transaction abandons it: no resp pulse, mem strobes drop next cycle.
- All outputs registered. States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: data request = data_read|data_write. Only one requester -> grant it. Both -> grant the client opposite last_grant. Granting latches address, op, mbe, wdata; update last_grant; go BUSY_x. No request -> stay.
- BUSY_x: mem_read or mem_write asserted from latched regs every cycle until mem_resp=1; mem_addr/mbe/wdata stable throughout. Inst: mem_read=1, mem_mbe=4'b1111, mem_wdata=0. Data read: mem_mbe=4'b1111. Data write: mem_mbe=latched data_mbe (write issued even if 0).
- data_read and data_write both 1 at grant: performed as write, err set.
- mem_resp=1 in BUSY_x: capture mem_rdata into x_rdata (reads only; writes leave data_rdata unchanged); go RESP_x.
- RESP_x: x_resp=1 for exactly this cycle, mem strobes 0, no grant; go IDLE. Client drops/changes request the following cycle; IDLE does not sample during RESP, so no duplicate issue.
- Minimum turnaround: request sampled cycle 0, strobe cycle 1, mem_resp cycle 1, x_resp cycle 2, next grant evaluated cycle 3.
- mem_resp in IDLE/RESP ignored.
- Watchdog: counter clears on entering BUSY, increments each BUSY cycle without mem_resp, saturates; reaching TIMEOUT_CYCLES sets err. No abort; transaction continues. err clears only on reset.
- inst_resp and data_resp never high in the same cycle.

Test Plan:
- Reset: hold rst=0 3 cycles with inst_read=1 -> all outputs 0, no mem_read; release -> mem_read=1, mem_addr=inst_addr next cycle.
- Single fetch: inst_addr=0x60, mem_resp 1 cycle after mem_read with mem_rdata=0x00A00093 -> inst_resp one cycle, inst_rdata=0x00A00093 held afterward.
- Store: data_write=1, addr 0x100, mbe 4'b0011, wdata 0xDEADBEEF -> mem_write=1, mem_mbe=4'b0011, fields stable 4 wait cycles; data_resp pulses; data_rdata unchanged.
- Contention: inst_read and data_read both held over 4 transactions -> grants INST, DATA, INST, DATA; never simultaneous resp.
- Watchdog: TIMEOUT_CYCLES=8, mem_resp withheld -> err=1 after 8 BUSY cycles, mem_read stays 1; later mem_resp completes normally, err stays 1.
- Abort: rst=0 during BUSY_D -> no data_resp, mem_write 0 after reset edge, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges the instruction-fetch and data ports of the core onto
// one request/response memory port. Requests are granted one at a time, with
// alternating priority when both clients ask at once. Every output is registered.
// A watchdog raises a sticky err when the memory stalls too long.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_resp,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mbe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } state_t;

  localparam logic        GRANT_INST = 1'b0;
  localparam logic        GRANT_DATA = 1'b1;
  localparam logic [31:0] LP_TIMEOUT = TIMEOUT_CYCLES;
  localparam logic [31:0] WD_MAX     = 32'hFFFF_FFFF;

  state_t      r_state,      w_state_next;
  logic        r_last_grant, w_last_grant_next;
  logic [31:0] r_wd_cnt,     w_wd_cnt_next;
  logic        r_err,        w_err_next;
  logic        r_mem_read,   w_mem_read_next;
  logic        r_mem_write,  w_mem_write_next;
  logic [3:0]  r_mem_mbe,    w_mem_mbe_next;
  logic [31:0] r_mem_addr,   w_mem_addr_next;
  logic [31:0] r_mem_wdata,  w_mem_wdata_next;
  logic [31:0] r_inst_rdata, w_inst_rdata_next;
  logic        r_inst_resp,  w_inst_resp_next;
  logic [31:0] r_data_rdata, w_data_rdata_next;
  logic        r_data_resp,  w_data_resp_next;

  logic        w_data_req;
  logic        w_grant_inst;
  logic [31:0] w_wd_inc;
  logic        w_wd_trip;

  // Inst wins when it is alone or when data was the previous winner.
  assign w_data_req   = data_read | data_write;
  assign w_grant_inst = inst_read & (~w_data_req | (r_last_grant == GRANT_DATA));

  // Saturating watchdog increment; a zero timeout disables tripping.
  assign w_wd_inc  = (r_wd_cnt == WD_MAX) ? r_wd_cnt : (r_wd_cnt + 32'd1);
  assign w_wd_trip = (LP_TIMEOUT != 32'd0) && (w_wd_inc >= LP_TIMEOUT);

  assign inst_rdata = r_inst_rdata;
  assign inst_resp  = r_inst_resp;
  assign data_rdata = r_data_rdata;
  assign data_resp  = r_data_resp;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_mbe    = r_mem_mbe;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign err        = r_err;

  // Next-state and next-output logic for the grant/busy/response sequence.
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_wd_cnt_next     = r_wd_cnt;
    w_err_next        = r_err;
    w_mem_read_next   = r_mem_read;
    w_mem_write_next  = r_mem_write;
    w_mem_mbe_next    = r_mem_mbe;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_inst_rdata_next = r_inst_rdata;
    w_data_rdata_next = r_data_rdata;
    w_inst_resp_next  = 1'b0;
    w_data_resp_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (inst_read || w_data_req) begin
          w_wd_cnt_next = 32'd0;
          if (w_grant_inst) begin
            w_state_next      = ST_BUSY_I;
            w_last_grant_next = GRANT_INST;
            w_mem_read_next   = 1'b1;
            w_mem_write_next  = 1'b0;
            w_mem_mbe_next    = 4'b1111;
            w_mem_addr_next   = inst_addr;
            w_mem_wdata_next  = 32'd0;
          end else begin
            w_state_next      = ST_BUSY_D;
            w_last_grant_next = GRANT_DATA;
            w_mem_addr_next   = data_addr;
            if (data_write) begin
              // A simultaneous read+write is treated as a write and flagged.
              w_mem_read_next  = 1'b0;
              w_mem_write_next = 1'b1;
              w_mem_mbe_next   = data_mbe;
              w_mem_wdata_next = data_wdata;
              w_err_next       = r_err | data_read;
            end else begin
              w_mem_read_next  = 1'b1;
              w_mem_write_next = 1'b0;
              w_mem_mbe_next   = 4'b1111;
              w_mem_wdata_next = 32'd0;
            end
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_resp) begin
          w_mem_read_next  = 1'b0;
          w_mem_write_next = 1'b0;
          if (r_state == ST_BUSY_I) begin
            w_state_next      = ST_RESP_I;
            w_inst_resp_next  = 1'b1;
            w_inst_rdata_next = mem_rdata;
          end else begin
            w_state_next     = ST_RESP_D;
            w_data_resp_next = 1'b1;
            if (!r_mem_write) begin
              w_data_rdata_next = mem_rdata;
            end else begin
              w_data_rdata_next = r_data_rdata;
            end
          end
        end else begin
          // Stall cycle: keep strobes and fields, advance the watchdog.
          w_wd_cnt_next = w_wd_inc;
          w_err_next    = r_err | w_wd_trip;
        end
      end

      ST_RESP_I, ST_RESP_D: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next     = ST_IDLE;
        w_mem_read_next  = 1'b0;
        w_mem_write_next = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_DATA;
      r_wd_cnt     <= 32'd0;
      r_err        <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_mbe    <= 4'd0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_inst_rdata <= 32'd0;
      r_inst_resp  <= 1'b0;
      r_data_rdata <= 32'd0;
      r_data_resp  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_wd_cnt     <= w_wd_cnt_next;
      r_err        <= w_err_next;
      r_mem_read   <= w_mem_read_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_mbe    <= w_mem_mbe_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_inst_rdata <= w_inst_rdata_next;
      r_inst_resp  <= w_inst_resp_next;
      r_data_rdata <= w_data_rdata_next;
      r_data_resp  <= w_data_resp_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, a transaction-level reference model
// compared every cycle, a behavioural memory responder, and literal checks.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        err;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  int mem_lat      = 0;
  bit mem_withhold = 1'b0;
  int waitc        = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_resp(inst_resp),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_resp(data_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0060) return 32'h00A0_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 = no transaction, 1 = waiting on memory, 2 = answering client
  int          m_phase;
  bit          m_last_was_data;
  bit          m_cur_data;
  int          m_stall;
  logic        e_inst_resp, e_data_resp, e_mem_read, e_mem_write, e_err;
  logic [3:0]  e_mem_mbe;
  logic [31:0] e_mem_addr, e_mem_wdata, e_inst_rdata, e_data_rdata;
  logic        m_want_data, m_pick_data;

  assign m_want_data = data_read | data_write;
  assign m_pick_data = m_want_data & ~(inst_read & m_last_was_data);

  // Reference model advanced on each rising edge from the current inputs.
  always @(posedge clk) begin
    if (!rst) begin
      m_phase <= 0; m_last_was_data <= 1'b1; m_cur_data <= 1'b0; m_stall <= 0;
      e_inst_resp <= 1'b0; e_data_resp <= 1'b0; e_mem_read <= 1'b0; e_mem_write <= 1'b0;
      e_err <= 1'b0; e_mem_mbe <= 4'd0; e_mem_addr <= 32'd0; e_mem_wdata <= 32'd0;
      e_inst_rdata <= 32'd0; e_data_rdata <= 32'd0;
    end else begin
      e_inst_resp <= 1'b0;
      e_data_resp <= 1'b0;
      if (m_phase == 0) begin
        if (inst_read || m_want_data) begin
          m_phase <= 1; m_stall <= 0;
          m_cur_data <= m_pick_data; m_last_was_data <= m_pick_data;
          if (m_pick_data) begin
            e_mem_addr  <= data_addr;
            e_mem_write <= data_write;
            e_mem_read  <= ~data_write;
            e_mem_mbe   <= data_write ? data_mbe : 4'b1111;
            e_mem_wdata <= data_wdata;
            if (data_read && data_write) e_err <= 1'b1;
          end else begin
            e_mem_addr <= inst_addr; e_mem_read <= 1'b1; e_mem_write <= 1'b0;
            e_mem_mbe <= 4'b1111; e_mem_wdata <= 32'd0;
          end
        end
      end else if (m_phase == 1) begin
        if (mem_resp) begin
          m_phase <= 2; e_mem_read <= 1'b0; e_mem_write <= 1'b0;
          if (m_cur_data) begin
            e_data_resp <= 1'b1;
            if (!e_mem_write) e_data_rdata <= mem_rdata;
          end else begin
            e_inst_resp <= 1'b1;
            e_inst_rdata <= mem_rdata;
          end
        end else begin
          m_stall <= m_stall + 1;
          if (TO != 0 && m_stall + 1 >= TO) e_err <= 1'b1;
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("inst_resp", {31'd0, inst_resp}, {31'd0, e_inst_resp});
      chk("data_resp", {31'd0, data_resp}, {31'd0, e_data_resp});
      chk("resp_excl", {31'd0, inst_resp & data_resp}, 32'd0);
      chk("mem_read", {31'd0, mem_read}, {31'd0, e_mem_read});
      chk("mem_write", {31'd0, mem_write}, {31'd0, e_mem_write});
      chk("err", {31'd0, err}, {31'd0, e_err});
      chk("inst_rdata", inst_rdata, e_inst_rdata);
      chk("data_rdata", data_rdata, e_data_rdata);
      if (e_mem_read || e_mem_write) begin
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_mbe", {28'd0, mem_mbe}, {28'd0, e_mem_mbe});
      end
      if (e_mem_write) chk("mem_wdata", mem_wdata, e_mem_wdata);
    end
  end

  // Behavioural memory: answers a strobe after mem_lat wait cycles.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_resp = 1'b0; waitc = 0;
      end else if (mem_resp) begin
        mem_resp = 1'b0; mem_rdata = 32'hBAD0_BAD0; waitc = 0;
      end else if ((mem_read || mem_write) && !mem_withhold) begin
        if (waitc >= mem_lat) begin
          mem_resp = 1'b1; mem_rdata = mem_word(mem_addr);
        end else begin
          waitc++;
        end
      end else if (!(mem_read || mem_write)) begin
        waitc = 0;
      end
    end
  end

  // sel: 0 inst_resp, 1 data_resp, 2 mem_read, 3 mem_write
  task automatic wait_for(input int sel, input string nm);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((sel == 0 && inst_resp) || (sel == 1 && data_resp) ||
          (sel == 2 && mem_read) || (sel == 3 && mem_write)) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_%s actual=timeout required=event", nm);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int order_q[$];
  int exp_order[4];

  // Directed stimulus sequence.
  initial begin
    rst = 1'b0; inst_read = 1'b1; inst_addr = 32'h0000_0060;
    data_read = 1'b0; data_write = 1'b0; data_mbe = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

    // Reset held for three edges with a fetch pending.
    @(posedge clk); #1 cmp_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_inst_resp", {31'd0, inst_resp}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;

    // Single fetch with zero memory latency.
    wait_for(2, "fetch_strobe");
    chk("fetch_addr", mem_addr, 32'h0000_0060);
    wait_for(0, "fetch_resp");
    inst_read = 1'b0;
    chk("fetch_rdata", inst_rdata, 32'h00A0_0093);
    repeat (3) @(negedge clk);
    chk("fetch_rdata_held", inst_rdata, 32'h00A0_0093);
    chk("fetch_resp_single", {31'd0, inst_resp}, 32'd0);

    // Store with four wait cycles.
    mem_lat = 4;
    data_write = 1'b1; data_addr = 32'h0000_0100; data_mbe = 4'b0011; data_wdata = 32'hDEAD_BEEF;
    wait_for(3, "store_strobe");
    chk("store_mbe", {28'd0, mem_mbe}, 32'h0000_0003);
    chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_for(1, "store_resp");
    data_write = 1'b0;
    chk("store_rdata_kept", data_rdata, 32'd0);

    // Contention: both clients held across four transactions.
    mem_lat = 1;
    inst_read = 1'b1; inst_addr = 32'h0000_0400;
    data_read = 1'b1; data_addr = 32'h0000_0800;
    for (int c = 0; c < 200 && order_q.size() < 4; c++) begin
      @(negedge clk);
      if (inst_resp) begin order_q.push_back(0); inst_addr = inst_addr + 32'd4; end
      if (data_resp) begin order_q.push_back(1); data_addr = data_addr + 32'd4; end
    end
    inst_read = 1'b0; data_read = 1'b0;
    chk("contend_count", order_q.size(), 32'd4);
    for (int k = 0; k < 4 && k < order_q.size(); k++) chk("contend_order", order_q[k], exp_order[k]);
    chk("contend_last_data", data_rdata, 32'h0804_F7FB);

    // Watchdog: memory silent for well past the timeout.
    mem_lat = 0; mem_withhold = 1'b1;
    inst_read = 1'b1; inst_addr = 32'h0000_0200;
    wait_for(2, "wd_strobe");
    repeat (7) @(negedge clk);
    chk("wd_err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("wd_err_set", {31'd0, err}, 32'd1);
    chk("wd_read_held", {31'd0, mem_read}, 32'd1);
    repeat (4) @(negedge clk);
    mem_withhold = 1'b0;
    wait_for(0, "wd_resp");
    inst_read = 1'b0;
    chk("wd_rdata", inst_rdata, 32'h0200_FDFF);
    repeat (2) @(negedge clk);
    chk("wd_err_sticky", {31'd0, err}, 32'd1);

    // Abort: reset while a store is outstanding.
    mem_withhold = 1'b1;
    data_write = 1'b1; data_addr = 32'h0000_0180; data_mbe = 4'b1111; data_wdata = 32'h55AA_55AA;
    wait_for(3, "abort_strobe");
    repeat (2) @(negedge clk);
    rst = 1'b0; data_write = 1'b0;
    @(negedge clk);
    chk("abort_write_low", {31'd0, mem_write}, 32'd0);
    chk("abort_no_resp", {31'd0, data_resp}, 32'd0);
    chk("abort_err_clr", {31'd0, err}, 32'd0);
    rst = 1'b1; mem_withhold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle", {30'd0, mem_read, mem_write}, 32'd0);
    end

    // Read and write requested together: issued as write, err raised.
    data_read = 1'b1; data_write = 1'b1;
    data_addr = 32'h0000_0300; data_mbe = 4'b1100; data_wdata = 32'h1234_5678;
    wait_for(3, "rw_strobe");
    chk("rw_no_read", {31'd0, mem_read}, 32'd0);
    chk("rw_mbe", {28'd0, mem_mbe}, 32'h0000_000C);
    chk("rw_err", {31'd0, err}, 32'd1);
    wait_for(1, "rw_resp");
    data_read = 1'b0; data_write = 1'b0;
    chk("rw_rdata_kept", data_rdata, 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
